// File: rtl/mdu_pkg.sv
// Shared op codes, FSM state type and op-class helpers for the HI/LO multiply/divide unit.
// Define MDU_MADD_EN to make madd/maddu/msub/msubu mult-class ops; otherwise they decode as NOP.
package mdu_pkg;

  localparam logic [3:0] MULT  = 4'd0;
  localparam logic [3:0] MULTU = 4'd1;
  localparam logic [3:0] DIV   = 4'd2;
  localparam logic [3:0] DIVU  = 4'd3;
  localparam logic [3:0] MTHI  = 4'd4;
  localparam logic [3:0] MTLO  = 4'd5;
  localparam logic [3:0] MADD  = 4'd6;
  localparam logic [3:0] MADDU = 4'd7;
  localparam logic [3:0] MSUB  = 4'd8;
  localparam logic [3:0] MSUBU = 4'd9;
  localparam logic [3:0] NOP   = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  function automatic logic is_mul_class(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return op inside {MULT, MULTU, MADD, MADDU, MSUB, MSUBU};
`else
    return op inside {MULT, MULTU};
`endif
  endfunction

  function automatic logic is_div_class(input logic [3:0] op);
    return op inside {DIV, DIVU};
  endfunction

  function automatic logic is_signed_mul(input logic [3:0] op);
    return op inside {MULT, MADD, MSUB};
  endfunction

  function automatic logic is_acc(input logic [3:0] op);
    return op inside {MADD, MADDU, MSUB, MSUBU};
  endfunction

  function automatic logic is_sub(input logic [3:0] op);
    return op inside {MSUB, MSUBU};
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational WIDTH-bit signed/unsigned divider with defined zero-divisor and MIN/-1 results.
module mdu_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             signed_i,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dz_o
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  always_comb begin
    quo_o = '1;
    rem_o = a_i;
    dz_o  = 1'b1;
    if (b_i != '0) begin
      dz_o = 1'b0;
      if (signed_i) begin
        if (a_i == MIN_VAL && b_i == '1) begin
          quo_o = MIN_VAL;
          rem_o = '0;
        end else begin
          quo_o = $signed(a_i) / $signed(b_i);
          rem_o = $signed(a_i) % $signed(b_i);
        end
      end else begin
        quo_o = a_i / b_i;
        rem_o = a_i % b_i;
      end
    end
  end

endmodule

// File: rtl/mdu_pipelined_unit.sv
// HI/LO multiply/divide unit: latency-modelling FSM, operand latches and optional accumulate.
// Build option MDU_MADD_EN enables madd/maddu/msub/msubu.
module mdu_pipelined_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             dz
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW      = $clog2(MAX_LAT + 1);

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               dz_q, dz_d;

  logic               idle, go, go_mul, go_div, done;
  logic [3:0]         cur_op;
  logic [WIDTH-1:0]   cur_a, cur_b, quo, rem;
  logic               div_dz;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod, hilo, acc;

  assign idle   = (state_q == ST_IDLE);
  assign go     = start & ~req & idle;
  assign go_mul = go & is_mul_class(op);
  assign go_div = go & is_div_class(op);
  assign busy   = ~idle | (start & ~req & (is_mul_class(op) | is_div_class(op)));

  // Live inputs feed the datapath in the issue cycle so a latency of 1 completes on the start edge.
  assign cur_op = idle ? op     : op_q;
  assign cur_a  = idle ? rs_val : a_q;
  assign cur_b  = idle ? rt_val : b_q;

  assign a_ext = is_signed_mul(cur_op) ? {{WIDTH{cur_a[WIDTH-1]}}, cur_a} : {{WIDTH{1'b0}}, cur_a};
  assign b_ext = is_signed_mul(cur_op) ? {{WIDTH{cur_b[WIDTH-1]}}, cur_b} : {{WIDTH{1'b0}}, cur_b};
  assign prod  = a_ext * b_ext;
  assign hilo  = {hi_q, lo_q};
  assign acc   = !is_acc(cur_op) ? prod : (is_sub(cur_op) ? hilo - prod : hilo + prod);

  mdu_divider #(.WIDTH(WIDTH)) u_div (
    .a_i      (cur_a),
    .b_i      (cur_b),
    .signed_i (cur_op == DIV),
    .quo_o    (quo),
    .rem_o    (rem),
    .dz_o     (div_dz)
  );

  always_comb begin
    done = 1'b0;
    case (state_q)
      ST_MUL:  done = (cnt_q == CW'(MUL_LAT - 1));
      ST_DIV:  done = (cnt_q == CW'(DIV_LAT - 1));
      default: done = (go_mul && MUL_LAT == 1) || (go_div && DIV_LAT == 1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dz_d    = dz_q;
    if (go) begin
      if (op == MTHI) begin
        hi_d = rs_val;
      end else if (op == MTLO) begin
        lo_d = rs_val;
      end else if (go_mul || go_div) begin
        state_d = go_mul ? ST_MUL : ST_DIV;
        cnt_d   = CW'(1);
        op_d    = op;
        a_d     = rs_val;
        b_d     = rt_val;
      end
    end else if (!idle) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (done) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      if (is_div_class(cur_op)) begin
        hi_d = rem;
        lo_d = quo;
        dz_d = div_dz;
      end else begin
        {hi_d, lo_d} = acc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= NOP;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dz_q    <= dz_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;
  assign dz = dz_q;

endmodule

// File: tb/tb_mdu_pipelined_unit.sv
// Scoreboard bench for mdu_pipelined_unit: directed corner cases then randomized ops vs. arithmetic model.
// Honours MDU_MADD_EN the same way the design build does.
module tb_mdu_pipelined_unit;
  import mdu_pkg::*;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  op = NOP;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        req = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, dz;

  mdu_pipelined_unit #(.WIDTH(32), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .req    (req),
    .hi     (hi),
    .lo     (lo),
    .busy   (busy),
    .dz     (dz)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t        sb[$];
  int          busy_last = -1;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic        m_dz = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: retires due results from the scoreboard and checks outputs every cycle.
  initial begin
    exp_t        e;
    logic [31:0] eh = '0, el = '0;
    logic        ed = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        e  = sb.pop_front();
        eh = e.hi;
        el = e.lo;
        ed = e.dz;
      end
      cmp("busy", 64'(busy), 64'(cyc <= busy_last));
      cmp("hi", 64'(hi), 64'(eh));
      cmp("lo", 64'(lo), 64'(el));
      cmp("dz", 64'(dz), 64'(ed));
    end
  end

  function automatic logic [31:0] neg(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  task automatic push(input int due);
    sb.push_back('{due: due, hi: m_hi, lo: m_lo, dz: m_dz});
  endtask

  task automatic model_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ua, ub, q, r;
    if (b == 0) begin
      m_lo = 32'hFFFF_FFFF; m_hi = a; m_dz = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      m_lo = 32'h8000_0000; m_hi = 0; m_dz = 1'b0;
    end else begin
      ua = (sgn && a[31]) ? neg(a) : a;
      ub = (sgn && b[31]) ? neg(b) : b;
      q  = ua / ub;
      r  = ua % ub;
      if (sgn && (a[31] ^ b[31])) q = neg(q);
      if (sgn && a[31]) r = neg(r);
      m_lo = q; m_hi = r; m_dz = 1'b0;
    end
  endtask

  function automatic logic [63:0] product(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb2;
    if (sgn) begin
      sa  = longint'($signed(a));
      sb2 = longint'($signed(b));
      return 64'(sa * sb2);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  task automatic drive(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic rq);
    logic [63:0] acc;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b; req = rq;
    if (!rq && cyc > busy_last) begin
      acc = {m_hi, m_lo};
      case (o)
        MTHI: begin m_hi = a; push(cyc + 1); end
        MTLO: begin m_lo = a; push(cyc + 1); end
        MULT, MULTU: begin
          {m_hi, m_lo} = product(o == MULT, a, b);
          push(cyc + ML); busy_last = cyc + ML - 1;
        end
`ifdef MDU_MADD_EN
        MADD, MADDU: begin
          {m_hi, m_lo} = acc + product(o == MADD, a, b);
          push(cyc + ML); busy_last = cyc + ML - 1;
        end
        MSUB, MSUBU: begin
          {m_hi, m_lo} = acc - product(o == MSUB, a, b);
          push(cyc + ML); busy_last = cyc + ML - 1;
        end
`endif
        DIV, DIVU: begin
          model_div(o == DIV, a, b);
          push(cyc + DL); busy_last = cyc + DL - 1;
        end
        default: ;
      endcase
    end
  endtask

  task automatic idle(input int n);
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0; req = 1'b0; op = NOP;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; req = 1'b0;
    sb.delete();
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    busy_last = -1;
    push(cyc);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_now(input string nm, input logic [31:0] eh, input logic [31:0] el, input logic ed);
    #2;
    cmp({nm, ".hi"}, 64'(hi), 64'(eh));
    cmp({nm, ".lo"}, 64'(lo), 64'(el));
    cmp({nm, ".dz"}, 64'(dz), 64'(ed));
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle(2);
    reset = 1'b0;
    idle(1);

    drive(MULT, neg(32'd3), 32'd7, 1'b0);
    idle(ML);
    chk_now("mult", 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    drive(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    drive(MULTU, 32'd5, 32'd5, 1'b0);
    idle(ML - 1);
    chk_now("multu", 32'h1, 32'hFFFF_FFFE, 1'b0);

    drive(DIV, neg(32'd7), 32'd2, 1'b0);
    idle(DL);
    chk_now("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    drive(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    idle(DL);
    chk_now("div_ovf", 32'h0, 32'h8000_0000, 1'b0);

    drive(DIVU, 32'd7, 32'd0, 1'b0);
    idle(DL);
    chk_now("divu_dz", 32'h7, 32'hFFFF_FFFF, 1'b1);
    drive(DIVU, 32'd9, 32'd3, 1'b0);
    idle(DL);
    chk_now("divu", 32'h0, 32'h3, 1'b0);

    drive(MTLO, 32'h10, 32'h0, 1'b1);
    idle(1);
    chk_now("mtlo_req", 32'h0, 32'h3, 1'b0);
    drive(MTLO, 32'h10, 32'h0, 1'b0);
    idle(1);
    chk_now("mtlo", 32'h0, 32'h10, 1'b0);

    drive(MULT, 32'd1234, 32'd5678, 1'b0);
    idle(2);
    do_reset();
    idle(ML + 3);
    chk_now("reset", 32'h0, 32'h0, 1'b0);

    drive(MTHI, 32'h0, 32'h0, 1'b0);
    drive(MTLO, 32'h10, 32'h0, 1'b0);
    drive(MADD, 32'd3, 32'd4, 1'b0);
    idle(ML);
`ifdef MDU_MADD_EN
    chk_now("madd", 32'h0, 32'h1C, 1'b0);
`else
    chk_now("madd_off", 32'h0, 32'h10, 1'b0);
`endif
    drive(MSUBU, 32'd1, 32'h1D, 1'b0);
    idle(ML);
`ifdef MDU_MADD_EN
    chk_now("msubu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
`else
    chk_now("msubu_off", 32'h0, 32'h10, 1'b0);
`endif

    for (int unsigned i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 2) idle(1);
      else drive(4'($urandom_range(0, 15)), rnd_val(), rnd_val(), ($urandom_range(0, 7) == 0));
    end
    idle(DL + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
